// File: rtl/dm_pkg.sv
// Shared types, MMIO register offsets and write-lane steering helpers for dm_responder.
package dm_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;

  // MMIO register word offsets (byte offset >> 2) inside the 32-byte window
  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] STATUS      = 3'd4;
  localparam logic [2:0] ERR_ADDR    = 3'd5;

  // Legal byte-lane write masks
  localparam logic [3:0] WEN_WORD    = 4'b1111;
  localparam logic [3:0] WEN_HALF_LO = 4'b0011;
  localparam logic [3:0] WEN_HALF_HI = 4'b1100;
  localparam logic [3:0] WEN_B0      = 4'b0001;
  localparam logic [3:0] WEN_B1      = 4'b0010;
  localparam logic [3:0] WEN_B2      = 4'b0100;
  localparam logic [3:0] WEN_B3      = 4'b1000;

  function automatic logic wen_legal(input logic [3:0] wen);
    return (wen == WEN_WORD) || (wen == WEN_HALF_LO) || (wen == WEN_HALF_HI) ||
           (wen == WEN_B0) || (wen == WEN_B1) || (wen == WEN_B2) || (wen == WEN_B3);
  endfunction

  // Store data arrives unshifted: halves take wd[15:0], bytes take wd[7:0].
  function automatic data_t lane_merge(input data_t old, input data_t wd, input logic [3:0] wen);
    data_t r;
    case (wen)
      WEN_WORD:    r = wd;
      WEN_HALF_LO: r = {old[31:16], wd[15:0]};
      WEN_HALF_HI: r = {wd[15:0], old[15:0]};
      WEN_B0:      r = {old[31:8], wd[7:0]};
      WEN_B1:      r = {old[31:16], wd[7:0], old[7:0]};
      WEN_B2:      r = {old[31:24], wd[7:0], old[15:0]};
      WEN_B3:      r = {wd[7:0], old[23:0]};
      default:     r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_responder_mtimer.sv
// Machine timer: prescaler, 64-bit mtime/mtimecmp with lane-steered CPU writes, registered irq.
module dm_mtimer
  import dm_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [1:0]  i_sel,
  input  logic [3:0]  i_wen,
  input  data_t       i_wd,
  output logic [63:0] o_mtime,
  output logic [63:0] o_mtimecmp,
  output logic        o_irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] r_pre;
  logic [63:0]   r_mtime, r_mtimecmp;
  logic          r_irq;
  logic          w_tick;
  logic [63:0]   w_inc, w_mtime_nxt, w_cmp_nxt;

  assign w_tick = (r_pre == PW'(TICK_DIV - 1));
  assign w_inc  = r_mtime + {63'd0, w_tick};

  // Next values: a CPU write to one half overrides that half only; the other keeps the carried increment
  always_comb begin
    w_mtime_nxt = w_inc;
    w_cmp_nxt   = r_mtimecmp;
    if (i_we) begin
      case (i_sel)
        MTIME_LO[1:0]:    w_mtime_nxt[31:0]  = lane_merge(r_mtime[31:0], i_wd, i_wen);
        MTIME_HI[1:0]:    w_mtime_nxt[63:32] = lane_merge(r_mtime[63:32], i_wd, i_wen);
        MTIMECMP_LO[1:0]: w_cmp_nxt[31:0]    = lane_merge(r_mtimecmp[31:0], i_wd, i_wen);
        default:          w_cmp_nxt[63:32]   = lane_merge(r_mtimecmp[63:32], i_wd, i_wen);
      endcase
    end
  end

  // Timer state; irq compares the pre-update values so it lags the condition by one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre      <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_irq      <= 1'b0;
    end else begin
      r_pre      <= w_tick ? '0 : r_pre + 1'b1;
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_cmp_nxt;
      r_irq      <= (r_mtime >= r_mtimecmp);
    end
  end

  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_mtimecmp;
  assign o_irq      = r_irq;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: word RAM, MMIO timer window and sticky bus-error capture.
module dm_responder
  import dm_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wd,
  input  logic [3:0]  i_wen,
  input  logic        i_ren,
  output logic [31:0] o_rd,
  output logic        o_timer_irq,
  output logic        o_bus_err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  data_t       r_mem [MEM_WORDS];
  logic        r_bus_err;
  addr_t       r_err_addr;

  logic        w_ram_hit, w_mmio_hit, w_unmapped;
  logic        w_wr, w_mask_ok, w_wr_ok;
  logic        w_err_set, w_err_clr, w_tmr_we;
  logic [2:0]  w_off;
  logic [AW-1:0] w_idx;
  logic [63:0] w_mtime, w_mtimecmp;
  data_t       w_rd;

  assign w_ram_hit  = (i_addr < 32'(MEM_WORDS * 4));
  assign w_mmio_hit = (i_addr[31:5] == MMIO_BASE[31:5]);
  assign w_unmapped = !w_ram_hit && !w_mmio_hit;
  assign w_idx      = i_addr[AW+1:2];
  assign w_off      = i_addr[4:2];

  assign w_wr      = |i_wen;
  assign w_mask_ok = wen_legal(i_wen);
  // Writes in the reset cycle are dropped
  assign w_wr_ok   = w_wr && w_mask_ok && !w_unmapped && !i_rst;
  assign w_tmr_we  = w_wr_ok && w_mmio_hit && !w_off[2];

  assign w_err_set = ((i_ren || w_wr) && w_unmapped) || (w_wr && !w_mask_ok);
  // Clear request is byte-0 bit 0 of a status store; if the same store is itself an
  // error (bad mask) the set still wins below.
  assign w_err_clr = w_wr && w_mmio_hit && (w_off == STATUS) && i_wen[0] && i_wd[0];

  dm_mtimer #(.TICK_DIV(TICK_DIV)) u_mtimer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (w_tmr_we),
    .i_sel      (w_off[1:0]),
    .i_wen      (i_wen),
    .i_wd       (i_wd),
    .o_mtime    (w_mtime),
    .o_mtimecmp (w_mtimecmp),
    .o_irq      (o_timer_irq)
  );

  // Combinational read mux; zero when not reading or unmapped
  always_comb begin
    w_rd = '0;
    if (i_ren) begin
      if (w_ram_hit) begin
        w_rd = r_mem[w_idx];
      end else if (w_mmio_hit) begin
        case (w_off)
          MTIME_LO:    w_rd = w_mtime[31:0];
          MTIME_HI:    w_rd = w_mtime[63:32];
          MTIMECMP_LO: w_rd = w_mtimecmp[31:0];
          MTIMECMP_HI: w_rd = w_mtimecmp[63:32];
          STATUS:      w_rd = {31'd0, r_bus_err};
          ERR_ADDR:    w_rd = r_err_addr;
          default:     w_rd = '0;
        endcase
      end
    end
  end

  assign o_rd = w_rd;

  // RAM write with byte-lane steering; contents are not reset
  always_ff @(posedge i_clk) begin
    if (w_wr_ok && w_ram_hit) begin
      r_mem[w_idx] <= lane_merge(r_mem[w_idx], i_wd, i_wen);
    end
  end

  // Sticky bus error: first address held unless a clear lands in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
    end else if (w_err_set) begin
      r_bus_err <= 1'b1;
      if (!r_bus_err || w_err_clr) r_err_addr <= i_addr;
    end else if (w_err_clr) begin
      r_bus_err <= 1'b0;
    end
  end

  assign o_bus_err = r_bus_err;

endmodule
